alarm_multi_core: RTL



---
 rtl/alarm_clock_pkg.sv | 28 ++
 rtl/bcd_time_counter.sv | 54 +++++
 rtl/alarm_multi_core.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alarm_clock_pkg.sv
// Shared types, digit limits and the BCD load-validation helper for the alarm clock core.
package alarm_clock_pkg;

   typedef struct packed {
      logic [3:0] hr_ms;
      logic [3:0] hr_ls;
      logic [3:0] min_ms;
      logic [3:0] min_ls;
   } bcd_time_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZED = 2'd2
   } ring_state_t;

   localparam logic [3:0] MAX_HR_MS      = 4'd2;
   localparam logic [3:0] MAX_HR_LS_AT_2 = 4'd3;
   localparam logic [3:0] MAX_MIN_MS     = 4'd5;
   localparam logic [3:0] MAX_DIGIT      = 4'd9;

   // A time is loadable only if it is a real 24-hour clock reading.
   function automatic logic bcd_time_valid(input bcd_time_t t);
      return ((t.hr_ms < MAX_HR_MS) || ((t.hr_ms == MAX_HR_MS) && (t.hr_ls <= MAX_HR_LS_AT_2)))
             && (t.hr_ls <= MAX_DIGIT) && (t.min_ms <= MAX_MIN_MS) && (t.min_ls <= MAX_DIGIT);
   endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// 24-hour BCD time-of-day register with validated load and minute tick.
// Also exposes the incremented value so the alarm match sees the post-tick time.
module bcd_time_counter
   import alarm_clock_pkg::*;
(
   input  logic      clock,
   input  logic      reset,
   input  logic      tick,
   input  logic      load,
   input  bcd_time_t load_value,
   output bcd_time_t time_value,
   output bcd_time_t time_next
);

   bcd_time_t time_r;

   // BCD increment with minute carry, hour carry and midnight wrap
   always_comb begin
      time_next = time_r;
      if (time_r.min_ls != MAX_DIGIT) begin
         time_next.min_ls = time_r.min_ls + 4'd1;
      end else if (time_r.min_ms != MAX_MIN_MS) begin
         time_next.min_ls = 4'd0;
         time_next.min_ms = time_r.min_ms + 4'd1;
      end else if ((time_r.hr_ms == MAX_HR_MS) && (time_r.hr_ls == MAX_HR_LS_AT_2)) begin
         time_next = bcd_time_t'(16'h0000);
      end else if (time_r.hr_ls != MAX_DIGIT) begin
         time_next.min_ls = 4'd0;
         time_next.min_ms = 4'd0;
         time_next.hr_ls  = time_r.hr_ls + 4'd1;
      end else begin
         time_next.min_ls = 4'd0;
         time_next.min_ms = 4'd0;
         time_next.hr_ls  = 4'd0;
         time_next.hr_ms  = time_r.hr_ms + 4'd1;
      end
   end

   // A load always swallows a same-cycle tick, even when the load itself is rejected
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         time_r <= bcd_time_t'(16'h0000);
      end else if (load) begin
         if (bcd_time_valid(load_value)) begin
            time_r <= load_value;
         end
      end else if (tick) begin
         time_r <= time_next;
      end
   end

   assign time_value = time_r;

endmodule

// File: rtl/alarm_multi_core.sv
// Multi-slot alarm clock core: alarm slots, lowest-index match priority and ring/snooze/stop FSM.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_multi_core
   import alarm_clock_pkg::*;
#(
   parameter int NUM_ALARMS = 4,
   parameter int SNOOZE_MIN = 5,
   parameter int RING_MIN   = 10,
   localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  one_minute,
   input  logic                  load_time,
   input  logic [15:0]           new_time,
   input  logic                  load_alarm,
   input  logic [AW-1:0]         alarm_sel,
   input  logic [15:0]           new_alarm,
   input  logic [NUM_ALARMS-1:0] alarm_en,
   input  logic                  snooze,
   input  logic                  stop,
   output logic [15:0]           current_time,
   output logic                  alarm_sound,
   output logic [AW-1:0]         ring_idx,
   output logic                  snoozed
);

   localparam logic [AW:0] SLOT_COUNT = (AW+1)'(NUM_ALARMS);
   localparam logic [5:0]  RING_LIM   = 6'(RING_MIN);

   logic [15:0]           slot_r [NUM_ALARMS];
   bcd_time_t             time_s;
   bcd_time_t             time_next_s;
   logic                  tick_s;
   logic                  slot_wr_s;
   logic                  ring_en_s;
   logic                  stop_s;
   logic [NUM_ALARMS-1:0] match_s;
   logic [AW-1:0]         first_s;
   ring_state_t           state_r;
   ring_state_t           state_n;
   logic [5:0]            cnt_r;
   logic [5:0]            cnt_n;
   logic [AW-1:0]         ring_idx_r;
   logic [AW-1:0]         ring_idx_n;
   logic                  sound_r;

   assign tick_s    = one_minute & ~load_time;
   assign slot_wr_s = load_alarm & bcd_time_valid(bcd_time_t'(new_alarm))
                      & ({1'b0, alarm_sel} < SLOT_COUNT);

   bcd_time_counter u_time (
      .clock      (clock),
      .reset      (reset),
      .tick       (tick_s),
      .load       (load_time),
      .load_value (new_time),
      .time_value (time_s),
      .time_next  (time_next_s)
   );

   // Alarm slot storage
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_ALARMS; i++) slot_r[i] <= 16'h0000;
      end else begin
         for (int i = 0; i < NUM_ALARMS; i++) begin
            if (slot_wr_s && (alarm_sel == AW'(i))) slot_r[i] <= new_alarm;
         end
      end
   end

   // Match vector, lowest-index encoder and enable of the slot currently ringing
   always_comb begin
      match_s   = {NUM_ALARMS{1'b0}};
      first_s   = {AW{1'b0}};
      ring_en_s = 1'b0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         match_s[i] = tick_s & alarm_en[i] & (slot_r[i] == time_next_s);
         if (match_s[i]) first_s = AW'(i);
         else            first_s = first_s;
         if (ring_idx_r == AW'(i)) ring_en_s = alarm_en[i];
         else                      ring_en_s = ring_en_s;
      end
   end

   // Dropping the enable of the ringing slot behaves exactly like stop
   assign stop_s = stop | ~ring_en_s;

`ifndef ALARM_SNOOZE_EN
   logic snooze_unused_s;
   assign snooze_unused_s = snooze;
`endif

   // Ring FSM next-state logic
   always_comb begin
      state_n    = state_r;
      cnt_n      = cnt_r;
      ring_idx_n = ring_idx_r;
      case (state_r)
         IDLE: begin
            if (|match_s) begin
               state_n    = RINGING;
               ring_idx_n = first_s;
               cnt_n      = 6'd0;
            end else begin
               state_n = IDLE;
            end
         end
         RINGING: begin
            if (stop_s) begin
               state_n = IDLE;
`ifdef ALARM_SNOOZE_EN
            end else if (snooze) begin
               state_n = SNOOZED;
               cnt_n   = 6'd0;
`endif
            end else if (tick_s) begin
               cnt_n = cnt_r + 6'd1;
               if (cnt_n == RING_LIM) state_n = IDLE;
               else                   state_n = RINGING;
            end else begin
               state_n = RINGING;
            end
         end
`ifdef ALARM_SNOOZE_EN
         SNOOZED: begin
            if (stop_s) begin
               state_n = IDLE;
            end else if (tick_s) begin
               if (cnt_r + 6'd1 == 6'(SNOOZE_MIN)) begin
                  state_n = RINGING;
                  cnt_n   = 6'd0;
               end else begin
                  cnt_n = cnt_r + 6'd1;
               end
            end else begin
               state_n = SNOOZED;
            end
         end
`endif
         default: begin
            state_n = IDLE;
            cnt_n   = 6'd0;
         end
      endcase
   end

   // State and registered outputs, decoded from the next state so they align with current_time
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         cnt_r      <= 6'd0;
         ring_idx_r <= {AW{1'b0}};
         sound_r    <= 1'b0;
      end else begin
         state_r    <= state_n;
         cnt_r      <= cnt_n;
         ring_idx_r <= ring_idx_n;
         sound_r    <= (state_n == RINGING);
      end
   end

`ifdef ALARM_SNOOZE_EN
   logic snoozed_r;

   // Snoozed indicator register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) snoozed_r <= 1'b0;
      else       snoozed_r <= (state_n == SNOOZED);
   end

   assign snoozed = snoozed_r;
`else
   assign snoozed = 1'b0;
`endif

   assign current_time = time_s;
   assign alarm_sound  = sound_r;
   assign ring_idx     = ring_idx_r;

endmodule
